// File: rtl/ras_pkg.sv
// Shared constants and operation decode for the fetch-stage return-address stack.
package ras_pkg;

  localparam int RAS_DEPTH = 8;
  localparam int RAS_PTR_W = 3;
  localparam int ADDR_W    = 32;

  typedef enum logic [2:0] {
    OP_IDLE  = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_REPL  = 3'd3,
    OP_FLUSH = 3'd4
  } ras_op_e;

  // flush dominates; a simultaneous push and pop replaces the top in place
  function automatic ras_op_e decode_op(input logic flush, input logic push, input logic pop);
    ras_op_e op_s;
    if (flush) begin
      op_s = OP_FLUSH;
    end else if (push && pop) begin
      op_s = OP_REPL;
    end else if (push) begin
      op_s = OP_PUSH;
    end else if (pop) begin
      op_s = OP_POP;
    end else begin
      op_s = OP_IDLE;
    end
    return op_s;
  endfunction

endpackage

// File: rtl/return_addr_stack_if.sv
// Push/pop/flush request bundle and stack status returned to the fetch stage.
interface return_addr_stack_if #(
  parameter int AW = ras_pkg::ADDR_W
);
  logic          push;
  logic [AW-1:0] push_addr;
  logic          pop;
  logic          flush;
  logic [AW-1:0] top_addr;
  logic          top_valid;
  logic          full;
  logic          underflow;
  logic          overflow;

  modport master (
    output push, push_addr, pop, flush,
    input  top_addr, top_valid, full, underflow, overflow
  );

  modport slave (
    input  push, push_addr, pop, flush,
    output top_addr, top_valid, full, underflow, overflow
  );
endinterface

// File: rtl/ras_regfile.sv
// Return-address storage: one synchronous write port, one asynchronous read port.
module ras_regfile import ras_pkg::*; #(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PTR_W = RAS_PTR_W,
  parameter int AW    = ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [AW-1:0]    wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [AW-1:0]    rdata
);

  logic [AW-1:0] mem_r [DEPTH];

  // entry storage, cleared asynchronously so a reset leaves top_addr at zero at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Circular return-address stack: overwrite-oldest on overflow, flushable, zero-latency top read.
module return_addr_stack import ras_pkg::*; #(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PTR_W = RAS_PTR_W,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  return_addr_stack_if.slave bus
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  ras_op_e          op_s;
  logic [PTR_W-1:0] tp_r, tp_nxt_s;
  logic [PTR_W:0]   count_r, count_nxt_s;
  logic             underflow_r, underflow_nxt_s;
  logic             overflow_r, overflow_nxt_s;
  logic             we_s;
  logic [PTR_W-1:0] waddr_s;
  logic [AW-1:0]    wdata_s;
  logic [AW-1:0]    rdata_s;
  logic             empty_s;
  logic             full_s;

  assign empty_s = (count_r == '0);
  assign full_s  = (count_r == CNT_FULL);

  // next pointer/count, write request and error pulses for this edge
  always_comb begin
    op_s            = decode_op(bus.flush, bus.push, bus.pop);
    tp_nxt_s        = tp_r;
    count_nxt_s     = count_r;
    underflow_nxt_s = 1'b0;
    overflow_nxt_s  = 1'b0;
    we_s            = 1'b0;
    waddr_s         = tp_r + PTR_ONE;
    wdata_s         = {bus.push_addr[AW-1:2], 2'b00};
    case (op_s)
      OP_FLUSH: begin
        count_nxt_s = '0;
      end
      OP_REPL: begin
        we_s = 1'b1;
        if (empty_s) begin
          tp_nxt_s    = tp_r + PTR_ONE;
          count_nxt_s = CNT_ONE;
        end else begin
          waddr_s = tp_r;
        end
      end
      OP_PUSH: begin
        we_s     = 1'b1;
        tp_nxt_s = tp_r + PTR_ONE;
        if (full_s) begin
          overflow_nxt_s = 1'b1;
        end else begin
          count_nxt_s = count_r + CNT_ONE;
        end
      end
      OP_POP: begin
        if (empty_s) begin
          underflow_nxt_s = 1'b1;
        end else begin
          tp_nxt_s    = tp_r - PTR_ONE;
          count_nxt_s = count_r - CNT_ONE;
        end
      end
      OP_IDLE: begin
        tp_nxt_s = tp_r;
      end
      default: begin
        tp_nxt_s = tp_r;
      end
    endcase
  end

  // control state and registered error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_r        <= '0;
      count_r     <= '0;
      underflow_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      tp_r        <= tp_nxt_s;
      count_r     <= count_nxt_s;
      underflow_r <= underflow_nxt_s;
      overflow_r  <= overflow_nxt_s;
    end
  end

  ras_regfile #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (tp_r),
    .rdata (rdata_s)
  );

  assign bus.top_addr  = rdata_s;
  assign bus.top_valid = !empty_s;
  assign bus.full      = full_s;
  assign bus.underflow = underflow_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_return_addr_stack.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a negedge monitor compares them.
module tb_return_addr_stack;

  logic clk;
  logic rst_n;

  return_addr_stack_if #(.AW(32)) bus ();

  return_addr_stack #(.DEPTH(8), .PTR_W(3), .AW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] top;
    logic        vld;
    logic        ful;
    logic        uf;
    logic        of;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one cycle of stimulus plus the outputs expected during that cycle (before its edge)
  task automatic cyc(input logic p, input logic [31:0] a, input logic po, input logic f,
                     input logic [31:0] etop, input logic ev, input logic ef,
                     input logic euf, input logic eof, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    bus.push      = p;
    bus.push_addr = a;
    bus.pop       = po;
    bus.flush     = f;
    e.nm = nm; e.top = etop; e.vld = ev; e.ful = ef; e.uf = euf; e.of = eof;
    sbq.push_back(e);
  endtask

  // monitor: compare DUT outputs against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if ({bus.top_addr, bus.top_valid, bus.full, bus.underflow, bus.overflow} !==
            {e.top, e.vld, e.ful, e.uf, e.of}) begin
          failures++;
          $display("FAIL %s: got top=%h v=%b full=%b uf=%b of=%b, want top=%h v=%b full=%b uf=%b of=%b",
                   e.nm, bus.top_addr, bus.top_valid, bus.full, bus.underflow, bus.overflow,
                   e.top, e.vld, e.ful, e.uf, e.of);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    bus.push = 1'b0; bus.push_addr = '0; bus.pop = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic LIFO order
    cyc(1, 32'h0040_0008, 0, 0, 32'h0000_0000, 0, 0, 0, 0, "reset_state");
    cyc(1, 32'h0040_0108, 0, 0, 32'h0040_0008, 1, 0, 0, 0, "push1");
    cyc(1, 32'h0040_0208, 0, 0, 32'h0040_0108, 1, 0, 0, 0, "push2");
    cyc(0, 32'h0,         1, 0, 32'h0040_0208, 1, 0, 0, 0, "pop_a");
    cyc(0, 32'h0,         1, 0, 32'h0040_0108, 1, 0, 0, 0, "pop_b");
    cyc(0, 32'h0,         1, 0, 32'h0040_0008, 1, 0, 0, 0, "pop_c");
    // underflow
    cyc(0, 32'h0,         1, 0, 32'h0000_0000, 0, 0, 0, 0, "empty_pop");
    cyc(0, 32'h0,         0, 0, 32'h0000_0000, 0, 0, 1, 0, "underflow_pulse");
    cyc(1, 32'h0040_0010, 0, 0, 32'h0000_0000, 0, 0, 0, 0, "underflow_clear");
    cyc(0, 32'h0,         1, 0, 32'h0040_0010, 1, 0, 0, 0, "push_after_uf");

    // overflow: 9 pushes into 8 entries, oldest lost
    for (int i = 0; i < 9; i++) begin
      cyc(1, 32'h1000 + 32'(8 * i), 0, 0,
          (i == 0) ? 32'h0 : 32'h1000 + 32'(8 * (i - 1)),
          (i > 0), (i == 8), 0, 0, $sformatf("ovf_push%0d", i));
    end
    for (int j = 0; j < 8; j++) begin
      cyc(0, 32'h0, 1, 0, 32'h1040 - 32'(8 * j), 1, (j == 0), 0, (j == 0),
          $sformatf("ovf_pop%0d", j));
    end
    cyc(1, 32'h2008, 0, 0, 32'h1040, 0, 0, 0, 0, "ovf_drained");

    // simultaneous push and pop replaces the top
    cyc(1, 32'h3008, 0, 0, 32'h2008, 1, 0, 0, 0, "repl_setup");
    cyc(1, 32'h4008, 1, 0, 32'h3008, 1, 0, 0, 0, "repl_old_top");
    cyc(0, 32'h0,    1, 0, 32'h4008, 1, 0, 0, 0, "repl_new_top");
    cyc(0, 32'h0,    1, 0, 32'h2008, 1, 0, 0, 0, "repl_below");
    cyc(1, 32'h8008, 1, 0, 32'h1040, 0, 0, 0, 0, "repl_count2");
    cyc(1, 32'h9008, 0, 0, 32'h8008, 1, 0, 0, 0, "repl_empty_push");

    // flush with push at count=5
    cyc(1, 32'h9108, 0, 0, 32'h9008, 1, 0, 0, 0, "fl_push3");
    cyc(1, 32'h9208, 0, 0, 32'h9108, 1, 0, 0, 0, "fl_push4");
    cyc(1, 32'h9308, 0, 0, 32'h9208, 1, 0, 0, 0, "fl_push5");
    cyc(1, 32'h5008, 0, 1, 32'h9308, 1, 0, 0, 0, "flush_cycle");
    cyc(1, 32'h6008, 0, 0, 32'h9308, 0, 0, 0, 0, "flushed");
    cyc(1, 32'hA008, 0, 0, 32'h6008, 1, 0, 0, 0, "post_flush_push");

    // asynchronous reset with count=4
    cyc(1, 32'hA108, 0, 0, 32'hA008, 1, 0, 0, 0, "ar_push2");
    cyc(1, 32'hA208, 0, 0, 32'hA108, 1, 0, 0, 0, "ar_push3");
    cyc(0, 32'h0,    0, 0, 32'hA208, 1, 0, 0, 0, "ar_count4");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    e.nm = "async_reset"; e.top = 32'h0; e.vld = 1'b0; e.ful = 1'b0; e.uf = 1'b0; e.of = 1'b0;
    sbq.push_back(e);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1, 32'h7003, 0, 0, 32'h0000_0000, 0, 0, 0, 0, "after_reset");
    cyc(0, 32'h0,    0, 0, 32'h7000,      1, 0, 0, 0, "addr_align");

    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations unchecked, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Hardware return-address stack for the MIPS core's fetch stage.
- Push side: the link-address producer (PC+8 of a jal/jalr) writes a return address.
- Pop side: the jr $ra handler reads the predicted return target and retires it.
- Circular, overwrite-oldest on overflow. Flushable on mispredict/exception.

Parameters:
DEPTH, 8, number of entries (power of two, 2..32)
PTR_W, 3, log2(DEPTH)
AW, 32, address width in bits

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
push  in  1  write push_addr as new top this cycle (jal/jalr retire)
push_addr  in  AW  return address (PC+8), word-aligned
pop  in  1  retire current top this cycle (jr $ra)
flush  in  1  discard all entries (pipeline flush)
top_addr  out  AW  current top entry (combinational read of mem[tp])
top_valid  out  1  stack holds at least one entry (count != 0)
full  out  1  count == DEPTH
underflow  out  1  registered one-cycle pulse: pop seen while empty
overflow  out  1  registered one-cycle pulse: push seen while full, not simultaneous with pop

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous):
  - tp=0, count=0, underflow=0, overflow=0, all entries cleared to 0.
  - Therefore top_addr=0, top_valid=0, full=0.
  - Reset mid-operation discards every entry immediately, with no clock edge required.
- State: tp (PTR_W bits, index of top entry), count (PTR_W+1 bits, 0..DEPTH), mem[DEPTH] of AW bits.
- Storage: push_addr[1:0] is ignored and stored as 00; top_addr[1:0] is always 0.
- Per-edge priority: flush > (push & pop) > push > pop > idle.
- flush: count<=0 and tp is unchanged. Entries are not cleared. push/pop in the same cycle are ignored. No pulses are raised.
- push only:
  - tp<=tp+1 mod DEPTH; mem[tp+1]<=push_addr.
  - count<=count+1, saturating at DEPTH.
  - If count==DEPTH, the oldest entry is overwritten (wrap) and overflow pulses on the next cycle.
- pop only:
  - If count>0: tp<=tp-1 mod DEPTH, count<=count-1. The popped value was top_addr in the pop cycle (zero latency).
  - If count==0: no state change; underflow pulses on the next cycle.
- push & pop together:
  - mem[tp]<=push_addr (replace top); tp and count unchanged. The consumer receives the old top_addr this cycle.
  - If count==0, this behaves as push only: count becomes 1 and no underflow is raised.
- top_addr/top_valid/full update the cycle after any state-changing edge. There are no write-to-read bypasses; the push value is visible from the next cycle.
- Pointer arithmetic is modulo DEPTH. count never exceeds DEPTH and never goes below 0.
- underflow/overflow are high for exactly one cycle per offending edge. They are low otherwise.

Decomposition:
- Shared package (ras_pkg): RAS_DEPTH, RAS_PTR_W, ADDR_W=32 constants, and an enum for operation select {OP_IDLE, OP_PUSH, OP_POP, OP_REPL, OP_FLUSH} decoded from flush/push/pop.
- One natural sub-module, ras_regfile: DEPTH x AW flops, one synchronous write port, one asynchronous read port, async clear on rst_n.
- return_addr_stack holds the pointer/count control and flag logic.

Test Plan:
- Reset then push 0x00400008, 0x00400108, 0x00400208 -> top_addr=0x00400208, count=3, top_valid=1. Three pops return 0x00400208, 0x00400108, 0x00400008 in order, then top_valid=0.
- Pop while empty -> underflow=1 for exactly one cycle, top_addr=0, state unchanged. Then push 0x00400010 -> top_addr=0x00400010.
- Push 9 addresses 0x1000+8*i (i=0..8) with DEPTH=8:
  - full=1 after the 8th push, overflow pulse after the 9th.
  - 8 pops return 0x1040 down to 0x1008; 0x1000 is lost. Then top_valid=0.
- With stack [0x2008, 0x3008], assert push=1 (0x4008) and pop=1 together:
  - top_addr=0x3008 during that cycle.
  - Next cycle top_addr=0x4008, count=2.
  - A following pop exposes 0x2008.
- With count=5, assert flush together with push (0x5008) -> next cycle count=0, top_valid=0, full=0, no pulses. A later push 0x6008 gives count=1, top_addr=0x6008.
- Drop rst_n asynchronously mid-cycle with count=4 -> top_valid=0, top_addr=0 before the next clock edge. push_addr=0x7003 after release -> top_addr=0x7000.
